// File: rtl/mvb_frame_tx.sv
// mvb_frame_tx
//   Single-clock MVB frame transmitter. Parallel words are buffered in an
//   internal FIFO. Each frame is serialised as Manchester half-bits:
//   start delimiter, data (MSB first), one check byte after every 64-bit
//   block, then an NL end delimiter. All bit timing comes from a
//   clock-enable divider.
//
// Ports
//   clk, rst              single clock, synchronous active-high reset
//   wr_en, wr_data        FIFO write port
//   fifo_full, fifo_level FIFO status (registered)
//   wr_ovf                pulse when a write is dropped on a full FIFO
//   start, frame_type,    frame request: master (16 bits) or slave with
//   len_code              length 16 << len_code (codes 0..4)
//   busy, done, err_start frame status
//   tx_out, tx_en         Manchester line data and driver enable
module mvb_frame_tx #(
    parameter int DATA_W       = 16,
    parameter int FIFO_DEPTH   = 32,
    parameter int HALFBIT_DIV  = 8,
    parameter int GAP_HALFBITS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          wr_ovf,
    input  logic                          start,
    input  logic                          frame_type,
    input  logic [2:0]                    len_code,
    output logic                          busy,
    output logic                          done,
    output logic                          err_start,
    output logic                          tx_out,
    output logic                          tx_en
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int DIV_W = $clog2(HALFBIT_DIV);
    localparam int WB_W  = $clog2(DATA_W);
    localparam int CNT_W = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DELIM = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_CRC   = 3'd3;
    localparam logic [2:0] ST_END   = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    // Delimiter half-bits, first half-bit in the MSB.
    localparam logic [17:0] MASTER_DELIM = 18'b10_11_00_01_11_00_01_01_01;
    localparam logic [17:0] SLAVE_DELIM  = 18'b10_10_10_10_00_11_10_00_11;

    // One LFSR step of G = x^7+x^6+x^5+x^2+1, data fed MSB first.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        crc7_step = {crc[5:0], 1'b0} ^ (fb ? 7'b1100101 : 7'b0000000);
    endfunction

    // Check byte: CRC plus even parity over block data and CRC, all inverted.
    function automatic logic [7:0] check_byte(input logic [6:0] crc, input logic data_par);
        check_byte = ~{crc, data_par ^ (^crc)};
    endfunction

    // ---------------- FIFO ----------------
    logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [LVL_W-1:0]  lvl_nxt_s;
    logic              wr_do_s, pop_s;
    logic [DATA_W-1:0] head_s;

    // A write into a full FIFO still succeeds when a pop frees a slot that cycle.
    assign wr_do_s = wr_en && (!fifo_full || pop_s);
    assign head_s  = mem_r[rd_ptr_r];

    // Next FIFO fill level.
    always_comb begin
        lvl_nxt_s = fifo_level;
        case ({wr_do_s, pop_s})
            2'b10:   lvl_nxt_s = fifo_level + LVL_W'(1);
            2'b01:   lvl_nxt_s = fifo_level - LVL_W'(1);
            default: lvl_nxt_s = fifo_level;
        endcase
    end

    // FIFO pointers, level and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_level <= {LVL_W{1'b0}};
            fifo_full  <= 1'b0;
            wr_ovf     <= 1'b0;
        end else begin
            if (wr_do_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)   rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            fifo_level <= lvl_nxt_s;
            fifo_full  <= (lvl_nxt_s == LVL_W'(FIFO_DEPTH));
            wr_ovf     <= wr_en && !wr_do_s;
        end
    end

    // FIFO storage (no reset needed, contents qualified by the pointers).
    always_ff @(posedge clk) begin
        if (wr_do_s) mem_r[wr_ptr_r] <= wr_data;
    end

    // ---------------- transmitter ----------------
    logic [2:0]        state_r;
    logic [DIV_W-1:0]  div_r;
    logic              half_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              ftype_r;
    logic [8:0]        bits_left_r;
    logic [5:0]        blk_r;
    logic [WB_W-1:0]   wbit_r;
    logic [DATA_W-1:0] shift_r;
    logic [6:0]        crc_r;
    logic              par_r;
    logic [7:0]        chk_r;

    logic              tick_s, sym_end_s, len_ok_s, can_go_s;
    logic [8:0]        n_bits_s, words_s;
    logic              bit_s, par_nxt_s, last_in_blk_s, word_end_s;
    logic [6:0]        crc_nxt_s;
    logic [17:0]       delim_s;
    logic [4:0]        delim_idx_s;
    logic              line_s, active_s, done_s;

    assign tick_s        = (div_r == DIV_W'(HALFBIT_DIV - 1));
    assign sym_end_s     = tick_s && half_r;
    assign n_bits_s      = 9'd16 << (frame_type ? len_code : 3'd0);
    assign words_s       = n_bits_s >> WB_W;
    assign len_ok_s      = !frame_type || (len_code <= 3'd4);
    assign can_go_s      = len_ok_s && (32'(fifo_level) >= 32'(words_s));
    assign bit_s         = shift_r[DATA_W-1];
    assign crc_nxt_s     = crc7_step(crc_r, bit_s);
    assign par_nxt_s     = par_r ^ bit_s;
    assign last_in_blk_s = (bits_left_r == 9'd1) || (blk_r == 6'd63);
    assign word_end_s    = (wbit_r == WB_W'(DATA_W - 1));
    assign delim_s       = ftype_r ? SLAVE_DELIM : MASTER_DELIM;
    assign delim_idx_s   = 5'd17 - {cnt_r[3:0], half_r};
    assign active_s      = (state_r == ST_DELIM) || (state_r == ST_DATA) ||
                           (state_r == ST_CRC)   || (state_r == ST_END);
    // First cycle of GAP: the final NL half-bit has just ended.
    assign done_s        = (state_r == ST_GAP) && (cnt_r == CNT_W'(0)) &&
                           (div_r == DIV_W'(0));

    // Pop a word exactly when the symbol before its MSB ends.
    assign pop_s = sym_end_s &&
                   (((state_r == ST_DELIM) && (cnt_r == CNT_W'(8))) ||
                    ((state_r == ST_DATA) && !last_in_blk_s && word_end_s) ||
                    ((state_r == ST_CRC) && (cnt_r == CNT_W'(7)) &&
                     (bits_left_r != 9'd0)));

    // Line level for the half-bit currently being produced.
    always_comb begin
        line_s = 1'b0;
        case (state_r)
            ST_DELIM: line_s = delim_s[delim_idx_s];
            ST_DATA:  line_s = bit_s ^ half_r;
            ST_CRC:   line_s = chk_r[7] ^ half_r;
            default:  line_s = 1'b0;
        endcase
    end

    // Frame sequencer: divider, symbol counters, data shifter and CRC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            div_r       <= {DIV_W{1'b0}};
            half_r      <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            ftype_r     <= 1'b0;
            bits_left_r <= 9'd0;
            blk_r       <= 6'd0;
            wbit_r      <= {WB_W{1'b0}};
            shift_r     <= {DATA_W{1'b0}};
            crc_r       <= 7'd0;
            par_r       <= 1'b0;
            chk_r       <= 8'd0;
            err_start   <= 1'b0;
        end else begin
            err_start <= 1'b0;
            if (state_r != ST_IDLE) begin
                div_r <= tick_s ? {DIV_W{1'b0}} : div_r + DIV_W'(1);
                if (tick_s) half_r <= ~half_r;
            end
            case (state_r)
                ST_IDLE: begin
                    div_r  <= {DIV_W{1'b0}};
                    half_r <= 1'b0;
                    cnt_r  <= {CNT_W{1'b0}};
                    if (start) begin
                        if (can_go_s) begin
                            state_r     <= ST_DELIM;
                            ftype_r     <= frame_type;
                            bits_left_r <= n_bits_s;
                        end else begin
                            err_start <= 1'b1;
                        end
                    end
                end
                ST_DELIM: begin
                    if (sym_end_s) begin
                        if (cnt_r == CNT_W'(8)) begin
                            state_r <= ST_DATA;
                            cnt_r   <= {CNT_W{1'b0}};
                            shift_r <= head_s;
                            wbit_r  <= {WB_W{1'b0}};
                            blk_r   <= 6'd0;
                            crc_r   <= 7'd0;
                            par_r   <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (sym_end_s) begin
                        crc_r       <= crc_nxt_s;
                        par_r       <= par_nxt_s;
                        bits_left_r <= bits_left_r - 9'd1;
                        if (last_in_blk_s) begin
                            state_r <= ST_CRC;
                            chk_r   <= check_byte(crc_nxt_s, par_nxt_s);
                            cnt_r   <= {CNT_W{1'b0}};
                            blk_r   <= 6'd0;
                        end else begin
                            blk_r <= blk_r + 6'd1;
                            if (word_end_s) begin
                                shift_r <= head_s;
                                wbit_r  <= {WB_W{1'b0}};
                            end else begin
                                shift_r <= {shift_r[DATA_W-2:0], 1'b0};
                                wbit_r  <= wbit_r + WB_W'(1);
                            end
                        end
                    end
                end
                ST_CRC: begin
                    if (sym_end_s) begin
                        chk_r <= {chk_r[6:0], 1'b0};
                        if (cnt_r == CNT_W'(7)) begin
                            cnt_r <= {CNT_W{1'b0}};
                            if (bits_left_r == 9'd0) begin
                                state_r <= ST_END;
                            end else begin
                                state_r <= ST_DATA;
                                shift_r <= head_s;
                                wbit_r  <= {WB_W{1'b0}};
                                crc_r   <= 7'd0;
                                par_r   <= 1'b0;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_END: begin
                    if (sym_end_s) begin
                        state_r <= ST_GAP;
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                end
                ST_GAP: begin
                    // GAP is counted in half-bits, not symbols.
                    if (tick_s) begin
                        if (cnt_r == CNT_W'(GAP_HALFBITS - 1)) begin
                            state_r <= ST_IDLE;
                            cnt_r   <= {CNT_W{1'b0}};
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Registered line and status outputs, one cycle behind the sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_out <= 1'b0;
            tx_en  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            tx_out <= active_s ? line_s : 1'b0;
            tx_en  <= active_s;
            busy   <= (state_r != ST_IDLE);
            done   <= done_s;
        end
    end

endmodule

// File: tb/tb_mvb_frame_tx.sv
module tb_mvb_frame_tx;

    localparam int GAP = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_type = 1'b0;
    logic [2:0]  len_code = 3'd0;

    logic        wr_en_a = 1'b0, start_a = 1'b0;
    logic [15:0] wr_data_a = 16'h0000;
    logic        fifo_full_a, wr_ovf_a, busy_a, done_a, err_a, tx_out_a, tx_en_a;
    logic [5:0]  fifo_level_a;

    logic        wr_en_b = 1'b0, start_b = 1'b0;
    logic [7:0]  wr_data_b = 8'h00;
    logic        fifo_full_b, wr_ovf_b, busy_b, done_b, err_b, tx_out_b, tx_en_b;
    logic [5:0]  fifo_level_b;

    int n_checks = 0;
    int n_pass   = 0;
    bit exp_q[$];
    bit dq_a[$];
    bit dq_b[$];
    bit stop_stream = 1'b0;
    int min_lvl;

    always #5 clk = ~clk;

    mvb_frame_tx #(.DATA_W(16), .FIFO_DEPTH(32), .HALFBIT_DIV(8), .GAP_HALFBITS(GAP)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_data(wr_data_a),
        .fifo_full(fifo_full_a), .fifo_level(fifo_level_a), .wr_ovf(wr_ovf_a),
        .start(start_a), .frame_type(frame_type), .len_code(len_code),
        .busy(busy_a), .done(done_a), .err_start(err_a), .tx_out(tx_out_a), .tx_en(tx_en_a)
    );

    mvb_frame_tx #(.DATA_W(8), .FIFO_DEPTH(32), .HALFBIT_DIV(4), .GAP_HALFBITS(GAP)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_data(wr_data_b),
        .fifo_full(fifo_full_b), .fifo_level(fifo_level_b), .wr_ovf(wr_ovf_b),
        .start(start_b), .frame_type(frame_type), .len_code(len_code),
        .busy(busy_b), .done(done_b), .err_start(err_b), .tx_out(tx_out_b), .tx_en(tx_en_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    // CRC by polynomial long division of M(x)*x^7 by G = x^7+x^6+x^5+x^2+1.
    function automatic logic [6:0] model_crc(input bit m[0:63], input int len);
        bit a[0:70];
        logic [7:0] g;
        logic [6:0] r;
        g = 8'b11100101;
        for (int i = 0; i < 71; i++) a[i] = 1'b0;
        for (int i = 0; i < len; i++) a[i] = m[i];
        for (int i = 0; i < len; i++)
            if (a[i]) for (int k = 0; k < 8; k++) a[i+k] ^= g[7-k];
        for (int j = 0; j < 7; j++) r[6-j] = a[len+j];
        return r;
    endfunction

    // Push the expected half-bit stream of one frame onto the scoreboard.
    task automatic model_frame(input bit sel, input bit slave, input int n);
        logic [17:0] d;
        bit blk[0:63];
        bit b, p;
        int nb;
        logic [6:0] c;
        logic [7:0] chk;
        d = slave ? 18'b101010100011100011 : 18'b101100011100010101;
        for (int i = 17; i >= 0; i--) exp_q.push_back(d[i]);
        nb = (n < 64) ? n : 64;
        for (int k = 0; k < n / nb; k++) begin
            p = 1'b0;
            for (int i = 0; i < nb; i++) begin
                b = sel ? dq_b.pop_front() : dq_a.pop_front();
                blk[i] = b;
                p ^= b;
                exp_q.push_back(b);
                exp_q.push_back(~b);
            end
            c = model_crc(blk, nb);
            p ^= ^c;
            chk = ~{c, p};
            for (int i = 7; i >= 0; i--) begin
                exp_q.push_back(chk[i]);
                exp_q.push_back(~chk[i]);
            end
        end
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
    endtask

    task automatic write_word(input bit sel, input logic [15:0] w);
        if (sel) begin
            wr_en_b = 1'b1; wr_data_b = w[7:0];
            for (int i = 7; i >= 0; i--) dq_b.push_back(w[i]);
        end else begin
            wr_en_a = 1'b1; wr_data_a = w;
            for (int i = 15; i >= 0; i--) dq_a.push_back(w[i]);
        end
        @(posedge clk); #1;
        wr_en_a = 1'b0; wr_en_b = 1'b0;
    endtask

    task automatic send_frame(input bit sel, input bit slave, input logic [2:0] lc);
        int n, c, h, div, busy_cnt, done_cnt;
        bit cur;
        logic o_out, o_en, o_busy, o_done;
        div = sel ? 4 : 8;
        n = slave ? (16 << lc) : 16;
        c = (n <= 64) ? 1 : n / 64;
        h = 18 + 2 * n + 16 * c + 2;
        model_frame(sel, slave, n);
        frame_type = slave; len_code = lc;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        check("err_on_accept", sel ? err_b : err_a, 1'b0);
        busy_cnt = 0; done_cnt = 0; cur = 1'b0;
        for (int j = 0; j < h * div; j++) begin
            @(posedge clk); #1;
            o_out = sel ? tx_out_b : tx_out_a; o_en = sel ? tx_en_b : tx_en_a;
            o_busy = sel ? busy_b : busy_a;   o_done = sel ? done_b : done_a;
            if (j % div == 0) cur = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
            check("tx_en", o_en, 1'b1);
            check("tx_out", o_out, cur);
            if (o_busy) busy_cnt++;
            if (o_done) done_cnt++;
        end
        for (int t = 0; t < 2000; t++) begin
            @(posedge clk); #1;
            o_out = sel ? tx_out_b : tx_out_a; o_en = sel ? tx_en_b : tx_en_a;
            o_busy = sel ? busy_b : busy_a;   o_done = sel ? done_b : done_a;
            if (t == 0) begin
                check("tx_en_fall", o_en, 1'b0);
                check("done_at_end", o_done, 1'b1);
                check("tx_out_idle", o_out, 1'b0);
            end
            if (o_done) done_cnt++;
            if (o_busy) busy_cnt++;
            else break;
        end
        check("busy_cycles", busy_cnt, (h + GAP) * div);
        check("done_count", done_cnt, 1);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_out", tx_out_a, 1'b0);
        check("rst_tx_en", tx_en_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_err", err_a, 1'b0);
        check("rst_ovf", wr_ovf_a, 1'b0);
        check("rst_full", fifo_full_a, 1'b0);
        check("rst_level", fifo_level_a, 6'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Master frame 0x1234
        write_word(0, 16'h1234);
        check("lvl_master", fifo_level_a, 6'd1);
        send_frame(0, 1'b0, 3'd0);
        check("lvl_after_master", fifo_level_a, 6'd0);

        // Slave 128-bit frame, 8 words
        for (int i = 0; i < 8; i++) write_word(0, 16'($urandom));
        check("lvl_slave_pre", fifo_level_a, 6'd8);
        send_frame(0, 1'b1, 3'd3);
        check("lvl_slave_post", fifo_level_a, 6'd0);

        // Illegal length code
        frame_type = 1'b1; len_code = 3'd6; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        check("err_illegal_len", err_a, 1'b1);
        check("busy_illegal_len", busy_a, 1'b0);
        @(posedge clk); #1;
        check("err_one_cycle", err_a, 1'b0);

        // Not enough words for a 256-bit frame
        for (int i = 0; i < 15; i++) write_word(0, 16'($urandom));
        check("lvl_15", fifo_level_a, 6'd15);
        len_code = 3'd4; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        check("err_short_fifo", err_a, 1'b1);
        @(posedge clk); #1;
        check("lvl_15_kept", fifo_level_a, 6'd15);
        check("busy_short_fifo", busy_a, 1'b0);
        write_word(0, 16'($urandom));
        send_frame(0, 1'b1, 3'd4);
        check("lvl_after_256", fifo_level_a, 6'd0);

        // FIFO full and overflow
        for (int i = 0; i < 32; i++) write_word(0, 16'($urandom));
        check("full_32", fifo_full_a, 1'b1);
        check("lvl_32", fifo_level_a, 6'd32);
        wr_en_a = 1'b1; wr_data_a = 16'hDEAD;
        @(posedge clk); #1;
        wr_en_a = 1'b0;
        check("ovf_pulse", wr_ovf_a, 1'b1);
        check("lvl_32_after_ovf", fifo_level_a, 6'd32);
        @(posedge clk); #1;
        check("ovf_one_cycle", wr_ovf_a, 1'b0);

        // Continuous writes while a full FIFO drains: every pop is refilled
        for (int i = 0; i < 16; i++)
            for (int b = 15; b >= 0; b--) dq_a.push_back(((16'hA5C3 >> b) & 16'h1) != 16'h0);
        stop_stream = 1'b0;
        min_lvl = 99;
        fork
            begin
                send_frame(0, 1'b1, 3'd4);
                stop_stream = 1'b1;
            end
            begin
                wr_data_a = 16'hA5C3; wr_en_a = 1'b1;
                while (!stop_stream) begin
                    @(posedge clk); #1;
                    if (int'(fifo_level_a) < min_lvl) min_lvl = int'(fifo_level_a);
                end
                wr_en_a = 1'b0;
            end
        join
        check("lvl_min_stream", min_lvl, 32);
        check("lvl_after_stream", fifo_level_a, 6'd32);
        send_frame(0, 1'b1, 3'd4);
        send_frame(0, 1'b1, 3'd4);
        check("lvl_drained", fifo_level_a, 6'd0);

        // Reset in the middle of DATA
        for (int i = 0; i < 3; i++) write_word(0, 16'($urandom));
        frame_type = 1'b1; len_code = 3'd1; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        check("pre_rst_tx_en", tx_en_a, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_tx_en", tx_en_a, 1'b0);
        check("mid_rst_tx_out", tx_out_a, 1'b0);
        check("mid_rst_busy", busy_a, 1'b0);
        check("mid_rst_level", fifo_level_a, 6'd0);
        dq_a.delete();
        exp_q.delete();
        write_word(0, 16'hBEEF);
        send_frame(0, 1'b0, 3'd0);

        // 8-bit FIFO, 4 cycles per half-bit, slave 32-bit frame
        write_word(1, 16'h0012);
        write_word(1, 16'h0034);
        write_word(1, 16'h0056);
        write_word(1, 16'h0078);
        check("b_lvl_pre", fifo_level_b, 6'd4);
        send_frame(1, 1'b1, 3'd1);
        check("b_lvl_post", fifo_level_b, 6'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
